// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and width helpers for the FIFO push arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: first valid requester scanning upward from ptr+1, wrapping at N
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [IW-1:0] idx;

    assign any = |valid;

    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (valid[idx]) pick = idx;
        end
    end

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// fifo_rr_push_arbiter: round-robin bounded-burst sharing of one FIFO write port
module fifo_rr_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LP_WIDTH  = 32,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*LP_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          push,
    output logic [LP_WIDTH-1:0]           data_in,
    input  logic                          pop,
    output logic [cnt_w(DEPTH)-1:0]       count,
    output logic                          full,
    output logic                          empty,
    output logic [id_w(NUM_REQ)-1:0]      grant_id,
    output logic                          err_underflow
);

    localparam int CW = cnt_w(DEPTH);
    localparam int IW = id_w(NUM_REQ);
    localparam int BW = id_w(MAX_BURST);

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick;
    logic          any;
    logic [BW-1:0] burst_cnt;
    logic          accept;
    logic          pop_eff;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .pick  (pick),
        .any   (any)
    );

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign req_ready = (state == BURST && !full) ? (NUM_REQ'(1) << grant_id) : '0;
    assign accept    = req_valid[grant_id] & req_ready[grant_id];
    assign pop_eff   = pop & !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= IW'(NUM_REQ - 1);
            grant_id      <= '0;
            burst_cnt     <= '0;
            push          <= 1'b0;
            data_in       <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else begin
            push          <= accept;
            count         <= count + CW'(accept) - CW'(pop_eff);
            err_underflow <= pop & empty;
            if (accept) data_in <= req_data[int'(grant_id)*LP_WIDTH +: LP_WIDTH];
            if (state == IDLE) begin
                if (any) begin
                    grant_id  <= pick;
                    rr_ptr    <= pick;
                    burst_cnt <= '0;
                    state     <= BURST;
                end
            end else begin
                if (accept) burst_cnt <= burst_cnt + BW'(1);
                if ((accept && burst_cnt == BW'(MAX_BURST - 1)) || !req_valid[grant_id]) state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// tb_fifo_rr_push_arbiter: directed plan scenarios plus random traffic against a reference model
module tb_fifo_rr_push_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             push;
    logic [W-1:0]     data_in;
    logic             pop = 1'b0;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic [1:0]       grant_id;
    logic             err_underflow;

    fifo_rr_push_arbiter #(.NUM_REQ(N), .LP_WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .grant_id      (grant_id),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner is the granted producer or -1 between grants.
    int          owner = -1, last = N - 1, beats = 0, occ = 0, gid = 0, acc_id = -1;
    bit          m_push = 0, m_err = 0;
    logic [W-1:0] m_data = '0;

    int          left [N];
    logic [W-1:0] base [N];
    int          sent [N];
    bit          rnd = 0;
    int          pop_pct = 0;
    logic [W-1:0] push_log [$];

    task automatic check_all();
        logic [N-1:0] r;
        r = '0;
        if (owner >= 0 && occ < D) r[owner] = 1'b1;
        chk("ready", req_ready, r);
        chk("push", push, m_push);
        chk("data_in", data_in, m_data);
        chk("count", count, occ);
        chk("full", full, occ == D);
        chk("empty", empty, occ == 0);
        chk("grant_id", grant_id, gid);
        chk("err_underflow", err_underflow, m_err);
    endtask

    task automatic model_edge();
        bit acc, pe;
        acc_id = -1;
        if (rst) begin
            owner = -1; last = N - 1; beats = 0; occ = 0; gid = 0;
            m_push = 0; m_err = 0; m_data = '0;
            return;
        end
        acc = owner >= 0 && req_valid[owner] && occ < D;
        pe  = pop && occ > 0;
        m_err  = pop && occ == 0;
        m_push = acc;
        if (acc) begin
            m_data = req_data[owner*W +: W];
            acc_id = owner;
        end
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && req_valid[(last + k) % N]) begin
                    owner = (last + k) % N;
                    last = owner; gid = owner; beats = 0;
                end
            end
        end else begin
            if (acc) beats++;
            if ((acc && beats == MB) || !req_valid[owner]) owner = -1;
        end
        occ = occ + int'(acc) - int'(pe);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rnd && left[i] == 0 && $urandom_range(0, 99) < 30) begin
                left[i] = $urandom_range(1, 9);
                base[i] = $urandom;
                sent[i] = 0;
            end
            req_valid[i] = left[i] > 0;
            req_data[i*W +: W] = base[i] + W'(sent[i]);
        end
        if (rnd) pop = $urandom_range(0, 99) < pop_pct;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        if (push) push_log.push_back(data_in);
        model_edge();
        @(posedge clk);
        #1;
        if (acc_id >= 0) begin
            left[acc_id]--;
            sent[acc_id]++;
        end
        drive();
    endtask

    task automatic load(input int i, input int n, input logic [W-1:0] b);
        left[i] = n; base[i] = b; sent[i] = 0;
        drive();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            left[i] = 0; base[i] = '0; sent[i] = 0;
        end
        #1;
        cyc();
        cyc();
        chk("rst_push", push, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;

        // one producer, four beats
        push_log.delete();
        load(0, 4, 32'hA0);
        repeat (8) cyc();
        chk("t1_beats", push_log.size(), 4);
        for (int i = 0; i < 4 && i < push_log.size(); i++) chk("t1_data", push_log[i], 32'hA0 + i);
        chk("t1_count", count, 4);

        // two producers alternating bursts, ends exactly full
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        push_log.delete();
        load(1, 8, 32'h10);
        load(2, 8, 32'h20);
        repeat (24) cyc();
        chk("t2_beats", push_log.size(), 16);
        for (int j = 0; j < 16 && j < push_log.size(); j++)
            chk("t2_order", push_log[j], ((j / 4) % 2 ? 32'h20 : 32'h10) + (j / 8) * 4 + (j % 4));
        chk("t2_full", full, 1);

        // full blocks, one pop frees a slot
        load(3, 1, 32'h30);
        repeat (3) cyc();
        chk("t3_ready_full", req_ready, 0);
        chk("t3_count16", count, 16);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("t3_count15", count, 15);
        chk("t3_ready", req_ready, 4'b1000);
        cyc();
        chk("t3_refill", count, 16);

        // pop at full with valid: no bypass, then accept+pop
        load(3, 2, 32'h38);
        cyc();
        pop = 1'b1;
        cyc();
        chk("t4_no_bypass", count, 15);
        cyc();
        chk("t4_acc_pop", count, 15);
        repeat (20) cyc();
        pop = 1'b0;
        cyc();
        chk("t5_drained", count, 0);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("t5_err", err_underflow, 1);
        chk("t5_count", count, 0);
        cyc();
        chk("t5_err_clear", err_underflow, 0);

        // reset in the middle of a burst
        load(3, 4, 32'h40);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("t6_push", push, 0);
        chk("t6_count", count, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) load(i, 2, 32'h50 + 16 * i);
        cyc();
        chk("t6_grant", grant_id, 0);
        chk("t6_ready", req_ready, 4'b0001);

        // random traffic
        rnd = 1;
        for (int ph = 0; ph < 4; ph++) begin
            pop_pct = 15 + 20 * ph;
            repeat (300) cyc();
        end
        rnd = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rr_push_arbiter.md
Name: fifo_rr_push_arbiter

Overview:
- Shares the single push/data_in write port of one `fifo` instance among NUM_REQ producers, using round-robin with bounded bursts.
- Tracks FIFO occupancy from its own pushes and the consumer's pop strobe, and backpressures producers when the FIFO is full.
- Sits directly in front of the FIFO write side. Producers use a valid/ready handshake.

Parameters:
- NUM_REQ, 4: number of producers (2..8).
- LP_WIDTH, 32: data width; matches the FIFO.
- DEPTH, 16: FIFO capacity in entries.
- MAX_BURST, 4: maximum beats accepted from one producer per grant (1..DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*LP_WIDTH  packed producer data; producer i occupies slice [i*LP_WIDTH +: LP_WIDTH]
- req_ready  out  NUM_REQ  per-producer accept, combinational
- push  out  1  FIFO write strobe, registered
- data_in  out  LP_WIDTH  FIFO write data, registered
- pop  in  1  consumer pop strobe to the FIFO, observed for occupancy
- count  out  $clog2(DEPTH+1)  reserved occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- grant_id  out  $clog2(NUM_REQ)  currently or most recently granted producer
- err_underflow  out  1  one-cycle pulse: pop seen while count == 0

Behaviour:
- Single clock; synchronous active-high reset. All state updates on posedge clk.
- Reset values: push=0, data_in=0, count=0, full=0, empty=1, grant_id=0, err_underflow=0, state=IDLE, burst_cnt=0, rr_ptr=NUM_REQ-1 (producer 0 wins first).
- State IDLE:
  - req_ready is all zeros.
  - If any req_valid: pick the first valid producer scanning from rr_ptr+1 modulo NUM_REQ; grant_id<=pick, rr_ptr<=pick, burst_cnt<=0, go to BURST.
  - This costs one arbitration bubble cycle per grant.
- State BURST:
  - req_ready[grant_id] = !full; all other req_ready bits are 0.
  - Accept = req_valid[grant_id] & req_ready[grant_id].
  - On accept: push<=1, data_in<=req_data slice of grant_id, burst_cnt<=burst_cnt+1. Otherwise push<=0 and data_in holds.
  - Exit to IDLE when accept && burst_cnt==MAX_BURST-1, or when req_valid[grant_id]==0.
  - full holds the state in BURST with no timeout; the producer keeps its grant.
- Latency: an accepted beat appears on push/data_in exactly 1 cycle after the accept edge.
- Occupancy (counts reservations, including one in-flight write):
  - pop_eff = pop & (count != 0).
  - count <= count + accept - pop_eff.
  - Accept and pop_eff in the same cycle leave count unchanged.
  - At count==DEPTH, full blocks accept even if pop is high in that cycle; there is no same-cycle bypass.
  - count never exceeds DEPTH and never goes below 0.
- Underflow: pop while count==0 is ignored for count, and err_underflow pulses high the next cycle.
- Producer rule: a producer holding valid must keep req_data stable until ready. The arbiter does not check this.
- Reset mid-burst: the next cycle is in reset state. Any in-flight push is dropped (push=0), and the FIFO must be reset in the same cycle.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_e enum {IDLE, BURST};
  - localparam helper functions for the count width and id width.
- One combinational sub-module, rr_pick: inputs are the valid vector and rr_ptr; outputs are the pick index and an any-valid flag. It is reusable by other arbiters.

Test Plan:
- Single producer 0 sends 4 beats 0xA0..0xA3 with valid held: IDLE bubble, then ready for 4 cycles; push high for 4 consecutive cycles carrying 0xA0..0xA3; count=4; back to IDLE.
- Producers 1 and 2 each hold valid for 8 beats, MAX_BURST=4: grants go 1,2,1,2 in bursts of 4; each switch costs one bubble; push sequence is 1-beats 0..3, 2-beats 0..3, 1-beats 4..7, 2-beats 4..7.
- Fill to DEPTH=16 with no pop: full=1, req_ready=0 at count 16. Then one pop: count=15, full=0, accept resumes the following cycle and count returns to 16.
- At count=16 with valid and pop both high: no accept that cycle, count=15. Next cycle, accept plus pop leaves count=15.
- pop while empty (count=0): count stays 0, err_underflow pulses 1 for one cycle.
- Assert rst in the middle of a 4-beat burst from producer 3: next cycle push=0, count=0, state IDLE. After release with all producers valid, producer 0 is granted first.
